dw_conv3x3: RTL and testbench

DW_CONV3X3 -- requirements
Module: dw_conv3x3

---
 rtl/mobilenet_pkg.sv | 29 ++
 rtl/dw_addr_gen.sv | 79 +++++++
 rtl/dw_conv3x3.sv | 116 +++++++++++
 tb/tb_dw_conv3x3.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mobilenet_pkg.sv
// Shared MobileNet accelerator definitions: default feature-map geometry,
// BRAM word size, the conv/batchnorm state encoding and the output clamp.
package mobilenet_pkg;

  localparam int iFM_R       = 6;
  localparam int iFM_C       = 6;
  localparam int K           = 3;
  localparam int BYTE_OFFSET = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KLOAD = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic signed [63:0] SAT_MAX = 64'sd2147483647;
  localparam logic signed [63:0] SAT_MIN = -64'sd2147483648;

  // Clamp a 64-bit accumulator into the signed 32-bit output word range.
  function automatic logic [31:0] sat32(input logic signed [63:0] v);
    if (v > SAT_MAX)      return 32'h7FFF_FFFF;
    else if (v < SAT_MIN) return 32'h8000_0000;
    else                  return v[31:0];
  endfunction

endpackage

// File: rtl/dw_addr_gen.sv
// Counter bank for the depthwise conv: kernel-load index n, tap (i,j) and
// output raster (r,c), plus the three BRAM byte addresses derived from them.
module dw_addr_gen #(
  parameter int iFM_R       = 6,
  parameter int iFM_C       = 6,
  parameter int K           = 3,
  parameter int BYTE_OFFSET = 4,
  parameter int CW          = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  mobilenet_pkg::state_t state,
  output logic [31:0]           kernel_addr,
  output logic [31:0]           iFM_addr,
  output logic [31:0]           oFM_pix_addr,
  output logic [CW-1:0]         kw_idx,
  output logic [CW-1:0]         tap_idx,
  output logic                  kload_last,
  output logic                  tap_last,
  output logic                  pix_last
);
  localparam int oFM_R = iFM_R - K + 1;
  localparam int oFM_C = iFM_C - K + 1;
  localparam logic [CW-1:0] KK_C  = CW'(K * K);
  localparam logic [CW-1:0] KM1   = CW'(K - 1);
  localparam logic [CW-1:0] ORM1  = CW'(oFM_R - 1);
  localparam logic [CW-1:0] OCM1  = CW'(oFM_C - 1);

  logic [CW-1:0] n, i, j, r, c;

  // Advance whichever counter the current state owns; IDLE rewinds everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      n <= '0; i <= '0; j <= '0; r <= '0; c <= '0;
    end else begin
      case (state)
        mobilenet_pkg::IDLE: begin
          n <= '0; i <= '0; j <= '0; r <= '0; c <= '0;
        end
        mobilenet_pkg::KLOAD: n <= n + 1'b1;
        mobilenet_pkg::MAC: begin
          if (j == KM1) begin
            j <= '0;
            i <= (i == KM1) ? '0 : i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        mobilenet_pkg::WRITE: begin
          if (c == OCM1) begin
            c <= '0;
            r <= r + 1'b1;
          end else begin
            c <= c + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Addresses are only live in the state that issues them, zero otherwise.
  always_comb begin
    kernel_addr  = '0;
    iFM_addr     = '0;
    if (state == mobilenet_pkg::KLOAD && n < KK_C)
      kernel_addr = 32'(BYTE_OFFSET) * 32'(n);
    if (state == mobilenet_pkg::MAC)
      iFM_addr = 32'(BYTE_OFFSET) *
                 ((32'(r) + 32'(i)) * 32'(iFM_C) + 32'(c) + 32'(j));
    oFM_pix_addr = 32'(BYTE_OFFSET) * (32'(r) * 32'(oFM_C) + 32'(c));
    kw_idx       = n;
    tap_idx      = CW'(32'(i) * 32'(K) + 32'(j));
    kload_last   = (n == KK_C);
    tap_last     = (i == KM1) && (j == KM1);
    pix_last     = (r == ORM1) && (c == OCM1);
  end

endmodule

// File: rtl/dw_conv3x3.sv
// Depthwise KxK convolution over one feature map held in BRAM. Loads the
// kernel once, then per output pixel streams K*K taps through a 64-bit MAC,
// saturates to 32 bits and writes one word to the downstream BRAM.
module dw_conv3x3 #(
  parameter int iFM_R       = mobilenet_pkg::iFM_R,
  parameter int iFM_C       = mobilenet_pkg::iFM_C,
  parameter int K           = mobilenet_pkg::K,
  parameter int BYTE_OFFSET = mobilenet_pkg::BYTE_OFFSET
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ps_control,
  output logic [31:0] pl_status,
  output logic [31:0] iFM_addr,
  input  logic [31:0] iFM_rddata,
  output logic [31:0] kernel_addr,
  input  logic [31:0] kernel_rddata,
  output logic [31:0] oFM_addr,
  output logic [31:0] oFM_wrdata,
  output logic [3:0]  oFM_we
);
  import mobilenet_pkg::*;

  localparam int CW = 8;
  localparam int KW = $clog2(K * K);

  state_t               state;
  logic signed [31:0]   weight [K*K];
  logic signed [63:0]   acc, acc_nxt, prod, ext_d, ext_w;
  logic                 tap_vld;
  logic [CW-1:0]        tap_d;
  logic [CW-1:0]        kw_idx, tap_idx;
  logic [31:0]          oFM_pix_addr;
  logic                 kload_last, tap_last, pix_last;
  logic                 unused_ctrl;

  assign unused_ctrl = ^ps_control[31:1];

  dw_addr_gen #(
    .iFM_R(iFM_R), .iFM_C(iFM_C), .K(K), .BYTE_OFFSET(BYTE_OFFSET), .CW(CW)
  ) u_addr (
    .clk(clk), .reset(reset), .state(state),
    .kernel_addr(kernel_addr), .iFM_addr(iFM_addr), .oFM_pix_addr(oFM_pix_addr),
    .kw_idx(kw_idx), .tap_idx(tap_idx),
    .kload_last(kload_last), .tap_last(tap_last), .pix_last(pix_last)
  );

  // Tap returned this cycle times the weight of the address issued last cycle.
  always_comb begin
    ext_d   = {{32{iFM_rddata[31]}}, iFM_rddata};
    ext_w   = {{32{weight[tap_d[KW-1:0]][31]}}, weight[tap_d[KW-1:0]]};
    prod    = ext_d * ext_w;
    acc_nxt = tap_vld ? acc + prod : acc;
  end

  // Control FSM with registered status/write outputs; DRAIN folds the last
  // tap and presents the clamped result so WRITE is a single strobe cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      acc        <= '0;
      tap_vld    <= 1'b0;
      tap_d      <= '0;
      pl_status  <= '0;
      oFM_addr   <= '0;
      oFM_wrdata <= '0;
      oFM_we     <= 4'h0;
      for (int k = 0; k < K*K; k++) weight[k] <= '0;
    end else begin
      tap_vld <= (state == MAC);
      tap_d   <= tap_idx;
      oFM_we  <= 4'h0;
      case (state)
        IDLE: begin
          pl_status <= '0;
          if (ps_control[0]) state <= KLOAD;
        end
        KLOAD: begin
          if (kw_idx != '0) weight[KW'(kw_idx - 1'b1)] <= kernel_rddata;
          if (kload_last) begin
            acc   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_nxt;
          if (tap_last) state <= DRAIN;
        end
        DRAIN: begin
          acc        <= acc_nxt;
          oFM_wrdata <= sat32(acc_nxt);
          oFM_addr   <= oFM_pix_addr;
          oFM_we     <= 4'hF;
          state      <= WRITE;
        end
        WRITE: begin
          acc <= '0;
          if (pix_last) begin
            pl_status <= 32'd1;
            state     <= DONE;
          end else begin
            state <= MAC;
          end
        end
        DONE: begin
          if (!ps_control[0]) begin
            pl_status <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dw_conv3x3.sv
// Directed bench for dw_conv3x3 with behavioural BRAMs for iFM, kernel and
// oFM; vector table for the arithmetic cases, hand sequences for control.
module tb_dw_conv3x3;
  localparam int NI  = 36;
  localparam int NK  = 9;
  localparam int NO  = 16;
  localparam int LAT = 186;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ps_control = '0;
  logic [31:0] pl_status, iFM_addr, iFM_rddata, kernel_addr, kernel_rddata;
  logic [31:0] oFM_addr, oFM_wrdata;
  logic [3:0]  oFM_we;

  logic [31:0] imem [NI];
  logic [31:0] kmem [NK];
  logic [31:0] omem [NO];
  int          hits [NO];
  int          hits_base [NO];
  int          wr_cnt = 0;
  int          bad_we = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  dw_conv3x3 dut (
    .clk(clk), .reset(reset), .ps_control(ps_control), .pl_status(pl_status),
    .iFM_addr(iFM_addr), .iFM_rddata(iFM_rddata),
    .kernel_addr(kernel_addr), .kernel_rddata(kernel_rddata),
    .oFM_addr(oFM_addr), .oFM_wrdata(oFM_wrdata), .oFM_we(oFM_we)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_i(input logic [31:0] a);
    int ix;
    ix = int'(a >> 2);
    if (ix < NI) return imem[ix];
    return 32'h0;
  endfunction

  function automatic logic [31:0] rd_k(input logic [31:0] a);
    int ix;
    ix = int'(a >> 2);
    if (ix < NK) return kmem[ix];
    return 32'h0;
  endfunction

  // Synchronous-read BRAMs: data one cycle after the address.
  always @(posedge clk) begin
    iFM_rddata    <= rd_i(iFM_addr);
    kernel_rddata <= rd_k(kernel_addr);
  end

  // Output BRAM write port plus write accounting.
  always @(posedge clk) begin
    int ox;
    if (oFM_we == 4'hF) begin
      ox = int'(oFM_addr >> 2);
      if (ox < NO) begin
        omem[ox] <= oFM_wrdata;
        hits[ox] <= hits[ox] + 1;
      end else begin
        bad_we <= bad_we + 1;
      end
      wr_cnt <= wr_cnt + 1;
    end else if (oFM_we != 4'h0) begin
      bad_we <= bad_we + 1;
    end
  end

  initial begin
    for (int k = 0; k < NO; k++) begin hits[k] = 0; omem[k] = '0; end
  end

  typedef struct {
    string       name;
    logic [31:0] ifm;       // constant iFM word
    bit          ifm_ramp;  // iFM[w] = w instead
    logic [31:0] w;         // weight value
    int          w_one;     // -1: all weights = w; else only this tap
    int          exp_kind;  // 0: constant exp; 1: ramp picked by tap w_one
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input vec_t v, input int k);
    int r, c, ti, tj;
    r = k / 4; c = k % 4;
    ti = v.w_one / 3; tj = v.w_one % 3;
    if (v.exp_kind == 1) return 32'((r + ti) * 6 + c + tj);
    return v.exp;
  endfunction

  task automatic load(input vec_t v);
    for (int w = 0; w < NI; w++) imem[w] = v.ifm_ramp ? 32'(w) : v.ifm;
    for (int n = 0; n < NK; n++) kmem[n] = (v.w_one < 0 || v.w_one == n) ? v.w : 32'h0;
  endtask

  task automatic snap(output int wc);
    for (int k = 0; k < NO; k++) hits_base[k] = hits[k];
    wc = wr_cnt;
  endtask

  // Raise start and count cycles from the first KLOAD cycle to first DONE.
  task automatic run_to_done(output int lat, output bit ok);
    ok = 1'b0;
    lat = 0;
    @(negedge clk); ps_control = 32'd1;
    @(posedge clk);
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(posedge clk); lat++; #1;
      if (pl_status == 32'd1) ok = 1'b1;
    end
    if (!ok) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_outputs(input string nm, input vec_t v, input int wc0);
    int nbad;
    nbad = 0;
    check({nm, "_writes"}, 32'(wr_cnt - wc0), 32'd16);
    for (int k = 0; k < NO; k++) begin
      if (hits[k] - hits_base[k] != 1) nbad++;
      check($sformatf("%s_out%0d", nm, k), omem[k], exp_word(v, k));
    end
    check({nm, "_one_write_each"}, 32'(nbad), 32'd0);
  endtask

  initial begin
    int lat, wc0, wc1, viol;
    bit ok;
    vecs[0] = '{"ones",    32'd1,         1'b0, 32'd1,         -1, 0, 32'd9};
    vecs[1] = '{"centre",  32'd0,         1'b1, 32'd1,          4, 1, 32'd0};
    vecs[2] = '{"tap1",    32'd0,         1'b1, 32'd1,          1, 1, 32'd0};
    vecs[3] = '{"tap0",    32'd0,         1'b1, 32'd1,          0, 1, 32'd0};
    vecs[4] = '{"tap8",    32'd0,         1'b1, 32'd1,          8, 1, 32'd0};
    vecs[5] = '{"neg",     32'd2,         1'b0, 32'hFFFF_FFFF, -1, 0, 32'hFFFF_FFEE};
    vecs[6] = '{"sat_pos", 32'h7FFF_FFFF, 1'b0, 32'd2,         -1, 0, 32'h7FFF_FFFF};
    vecs[7] = '{"sat_neg", 32'h8000_0000, 1'b0, 32'd2,         -1, 0, 32'h8000_0000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_pl_status", pl_status, 32'd0);
    check("rst_ifm_addr", iFM_addr, 32'd0);
    check("rst_kernel_addr", kernel_addr, 32'd0);
    check("rst_ofm_addr", oFM_addr, 32'd0);
    check("rst_ofm_wrdata", oFM_wrdata, 32'd0);
    check("rst_ofm_we", 32'(oFM_we), 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("idle_ofm_we", 32'(oFM_we), 32'd0);

    // Table-driven arithmetic vectors
    foreach (vecs[v]) begin
      load(vecs[v]);
      snap(wc0);
      run_to_done(lat, ok);
      check({vecs[v].name, "_latency"}, 32'(lat), 32'(LAT));
      check_outputs(vecs[v].name, vecs[v], wc0);
      @(negedge clk); ps_control = '0;
      repeat (2) @(posedge clk);
      #1 check({vecs[v].name, "_idle_status"}, pl_status, 32'd0);
    end

    // Start held past DONE: no retrigger, no extra writes
    load(vecs[0]);
    snap(wc0);
    run_to_done(lat, ok);
    viol = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (pl_status != 32'd1) viol++;
    end
    check("hold_status_drops", 32'(viol), 32'd0);
    check("hold_writes", 32'(wr_cnt - wc0), 32'd16);
    @(negedge clk); ps_control = '0;
    repeat (2) @(posedge clk);
    #1 check("hold_release_idle", pl_status, 32'd0);
    load(vecs[2]);
    snap(wc0);
    run_to_done(lat, ok);
    check("rerun_latency", 32'(lat), 32'(LAT));
    check_outputs("rerun", vecs[2], wc0);
    @(negedge clk); ps_control = '0;
    repeat (2) @(posedge clk);

    // Reset pulsed during pixel 5 MAC (cycle 68 from first KLOAD cycle)
    load(vecs[1]);
    snap(wc0);
    @(negedge clk); ps_control = 32'd1;
    @(posedge clk);
    repeat (68) @(posedge clk);
    @(negedge clk); reset = 1'b0; ps_control = '0;
    @(posedge clk);
    #1 check("midrst_ofm_we", 32'(oFM_we), 32'd0);
    check("midrst_wrdata", oFM_wrdata, 32'd0);
    @(negedge clk); reset = 1'b1;
    check("midrst_prior_writes", 32'(wr_cnt - wc0), 32'd5);
    wc1 = wr_cnt;
    viol = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (oFM_we != 4'h0 || oFM_wrdata != 32'd0 || pl_status != 32'd0) viol++;
    end
    check("midrst_quiet_cycles", 32'(viol), 32'd0);
    check("midrst_no_writes", 32'(wr_cnt - wc1), 32'd0);
    snap(wc0);
    run_to_done(lat, ok);
    check("postrst_latency", 32'(lat), 32'(LAT));
    check_outputs("postrst", vecs[1], wc0);
    @(negedge clk); ps_control = '0;
    repeat (2) @(posedge clk);

    check("we_encoding", 32'(bad_we), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
